// File: rtl/tinyalu_cmd_driver.sv
// tinyalu_cmd_driver: valid/ready command front end that drives the TinyALU start/done handshake
module tinyalu_cmd_driver #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [2:0]  cmd_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [2:0]  rsp_op,
  output logic        rsp_timeout,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP, GAP} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic legal;
  assign legal = cmd_op inside {3'd1, 3'd2, 3'd3, 3'd4};
  // Operation sequencer: accept, issue to the ALU under watchdog, hold the response, then one idle gap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      cmd_ready   <= 1'b1;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      alu_start   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_op      <= '0;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          cmd_ready <= 1'b0;
          busy      <= 1'b1;
          rsp_op    <= cmd_op;
          if (legal) begin
            state     <= ISSUE;
            alu_a     <= cmd_a;
            alu_b     <= cmd_b;
            alu_op    <= cmd_op;
            alu_start <= 1'b1;
            cnt       <= CNT_W'(1);
          end else begin
            state       <= RESP;
            rsp_valid   <= 1'b1;
            rsp_result  <= '0;
            rsp_timeout <= 1'b0;
          end
        end
        ISSUE: if (alu_done || cnt == CNT_W'(TIMEOUT_CYCLES)) begin
          state       <= RESP;
          alu_start   <= 1'b0;
          rsp_valid   <= 1'b1;
          rsp_result  <= alu_done ? alu_result : 16'h0;
          rsp_timeout <= !alu_done;
        end else begin
          cnt <= cnt + 1'b1;
        end
        RESP: if (rsp_ready) begin
          state     <= GAP;
          rsp_valid <= 1'b0;
        end
        GAP: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tinyalu_cmd_driver.sv
// tb_tinyalu_cmd_driver: vector table, corner sequences and random ops against an ALU model and reference
module tb_tinyalu_cmd_driver;
  logic clk = 0, reset_n = 1;
  logic cmd_valid = 0, cmd_ready;
  logic [7:0] cmd_a = 0, cmd_b = 0, alu_a, alu_b;
  logic [2:0] cmd_op = 0, alu_op, rsp_op;
  logic alu_start, alu_done, rsp_valid, rsp_ready = 0, rsp_timeout, busy;
  logic [15:0] alu_result, rsp_result;
  int tests = 0, failed = 0;
  int alu_lat = 1, sc = 0, cyc = 0;
  logic stray = 0;
  int acc_q[$];

  tinyalu_cmd_driver dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_start(alu_start), .alu_done(alu_done), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_op(rsp_op), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  // TinyALU stand-in: done after alu_lat cycles of start (0 = never), stray injects done anytime
  always @(posedge clk) sc <= alu_start ? sc + 1 : 0;
  assign alu_done = stray || (alu_start && alu_lat != 0 && sc == alu_lat - 1);
  always_comb begin
    alu_result = 16'h0;
    case (alu_op)
      3'd1: alu_result = {8'h0, alu_a} + {8'h0, alu_b};
      3'd2: alu_result = {8'h0, alu_a & alu_b};
      3'd3: alu_result = {8'h0, alu_a ^ alu_b};
      3'd4: alu_result = alu_a * alu_b;
      default: alu_result = 16'h0;
    endcase
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset_n && cmd_valid && cmd_ready) acc_q.push_back(cyc);
  end

  typedef struct {
    logic [7:0] a, b;
    logic [2:0] op;
    int lat, hold;
    logic [15:0] er;
    logic et;
    int es;
  } vec_t;

  function automatic logic [15:0] ref_res(logic [7:0] a, logic [7:0] b, logic [2:0] op);
    int x = 0;
    if (op == 1) x = int'(a) + int'(b);
    if (op == 2) x = int'(a & b);
    if (op == 3) x = int'(a ^ b);
    if (op == 4) x = int'(a) * int'(b);
    return 16'(x);
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                       input int lat, input int hold, input logic [15:0] er, input logic et, input int es);
    int t, starts;
    logic lg;
    lg = op >= 1 && op <= 4;
    alu_lat = lat;
    @(negedge clk);
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1;
    t = 0;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    check("accept", 32'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 0;
    check("start_latency", 32'(alu_start), 32'(lg));
    if (lg) check("alu_operands", {13'h0, alu_a, alu_b, alu_op}, {13'h0, a, b, op});
    starts = 0; t = 0;
    while (!rsp_valid && t < 100) begin
      if (alu_start) starts++;
      @(negedge clk); t++;
    end
    check("rsp_valid_seen", 32'(rsp_valid), 1);
    check("start_cycles", 32'(starts), 32'(es));
    check("start_low_in_resp", 32'(alu_start), 0);
    check("rsp_fields", {12'h0, rsp_result, rsp_op, rsp_timeout}, {12'h0, er, op, et});
    repeat (hold) begin
      stray = 1;
      @(negedge clk);
      stray = 0;
      check("resp_hold", {9'h0, rsp_valid, rsp_result, rsp_op, rsp_timeout, cmd_ready, busy},
            {9'h0, 1'b1, er, op, et, 1'b0, 1'b1});
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    check("gap", {cmd_ready, rsp_valid, alu_start, busy}, 4'b0001);
    @(negedge clk);
    check("back_idle", {cmd_ready, busy}, 2'b10);
  endtask

  initial begin
    vec_t v[$];
    v.push_back('{8'hFF, 8'h55, 3'd1, 1, 0, 16'h0154, 1'b0, 1});
    v.push_back('{8'hFF, 8'h55, 3'd4, 3, 0, 16'h54AB, 1'b0, 3});
    v.push_back('{8'hAA, 8'hEE, 3'd3, 1, 0, 16'h0044, 1'b0, 1});
    v.push_back('{8'hAA, 8'hEE, 3'd2, 1, 0, 16'h00AA, 1'b0, 1});
    v.push_back('{8'h12, 8'h34, 3'd0, 1, 0, 16'h0000, 1'b0, 0});
    v.push_back('{8'h12, 8'h34, 3'd6, 1, 0, 16'h0000, 1'b0, 0});
    v.push_back('{8'h10, 8'h20, 3'd1, 0, 0, 16'h0000, 1'b1, 16});
    v.push_back('{8'h01, 8'h02, 3'd1, 1, 0, 16'h0003, 1'b0, 1});
    v.push_back('{8'h0F, 8'hF0, 3'd3, 2, 10, 16'h00FF, 1'b0, 2});
    v.push_back('{8'h03, 8'h05, 3'd4, 16, 0, 16'h000F, 1'b0, 16});
    v.push_back('{8'h03, 8'h05, 3'd4, 17, 0, 16'h0000, 1'b1, 16});
    #1 reset_n = 0;
    #1 check("reset_outputs",
             {alu_a, alu_b, alu_op, alu_start, rsp_valid, rsp_result, rsp_op, rsp_timeout, busy, cmd_ready},
             {8'h0, 8'h0, 3'h0, 1'b0, 1'b0, 16'h0, 3'h0, 1'b0, 1'b0, 1'b1});
    repeat (2) @(negedge clk);
    reset_n = 1;
    foreach (v[i]) do_op(v[i].a, v[i].b, v[i].op, v[i].lat, v[i].hold, v[i].er, v[i].et, v[i].es);
    rsp_ready = 1; alu_lat = 1;
    @(negedge clk);
    acc_q.delete();
    cmd_a = 8'h21; cmd_b = 8'h13; cmd_op = 3'd1; cmd_valid = 1;
    repeat (12) @(negedge clk);
    cmd_valid = 0;
    repeat (5) @(negedge clk);
    rsp_ready = 0;
    check("b2b_accepts", 32'(acc_q.size()), 3);
    if (acc_q.size() == 3) begin
      check("b2b_spacing1", 32'(acc_q[1] - acc_q[0]), 4);
      check("b2b_spacing2", 32'(acc_q[2] - acc_q[1]), 4);
    end
    check("b2b_last_result", {16'h0, rsp_result}, 32'h0034);
    alu_lat = 0;
    @(negedge clk);
    cmd_a = 8'h07; cmd_b = 8'h09; cmd_op = 3'd1; cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0;
    repeat (3) @(negedge clk);
    check("pre_reset_start", 32'(alu_start), 1);
    #2 reset_n = 0;
    #1 check("mid_reset", {alu_start, rsp_valid, cmd_ready, busy}, 4'b0010);
    repeat (2) @(negedge clk);
    reset_n = 1;
    do_op(8'h01, 8'h01, 3'd1, 1, 0, 16'h0002, 1'b0, 1);
    for (int k = 0; k < 40; k++) begin
      logic [7:0] a, b;
      logic [2:0] op;
      int lat, hold;
      logic lg, to;
      a = 8'($urandom); b = 8'($urandom); op = 3'($urandom_range(0, 7));
      lat = $urandom_range(1, 20); hold = $urandom_range(0, 3);
      lg = op >= 1 && op <= 4;
      to = lg && lat > 16;
      do_op(a, b, op, lat, hold, (lg && !to) ? ref_res(a, b, op) : 16'h0, to,
            lg ? (lat > 16 ? 16 : lat) : 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
